// File: rtl/serializer.sv
// Parallel-to-serial converter: latches a word when idle and shifts it out MSB-first, one bit per clock.
// Latency: first bit one cycle after accept. Backpressure: input is ignored while busy_o is high; no stall on the output side.
module serializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic [MOD_WIDTH:0]        cnt_q, cnt_d;
  logic                      short_word;
  logic [MOD_WIDTH:0]        n_bits;

  // Lengths of 1 and 2 cannot be framed by the far-end deserializer, so they are dropped.
  assign short_word = (data_mod_i == MOD_WIDTH'(1)) || (data_mod_i == MOD_WIDTH'(2));
  assign n_bits     = (data_mod_i == '0) ? (MOD_WIDTH+1)'(DATA_BUS_WIDTH)
                                         : {1'b0, data_mod_i};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (data_val_i && !short_word) begin
        shift_d = data_i;
        cnt_d   = n_bits;
        state_d = SEND;
      end
    end else begin
      shift_d = {shift_q[DATA_BUS_WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
      if (cnt_d == '0) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate with state so a partially shifted word never leaks onto the line while idle.
  assign ser_data_val_o = (state_q == SEND);
  assign busy_o         = (state_q == SEND);
  assign ser_data_o     = shift_q[DATA_BUS_WIDTH-1] & (state_q == SEND);

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter; transmit-side counterpart of the team's 16-bit deserializer.
- Accepts one parallel word plus a bit count when idle, then shifts the word out MSB-first, one bit per clock, with a per-bit valid.
- Sits ahead of a serial link whose far end is the deserializer. Its ser_data_o/ser_data_val_o pair drives that block's data_i/data_val_i pair directly.

Parameters:
- DATA_BUS_WIDTH, 16, parallel word width in bits; must be a power of two and at least 4.
- MOD_WIDTH, $clog2(DATA_BUS_WIDTH), width of the bit-count input.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- arst_n_i  input  1  reset, asynchronous, active-low. Assertion clears all state immediately; deassertion takes effect at the next clk_i edge.
- data_i  input  DATA_BUS_WIDTH  parallel word; bit DATA_BUS_WIDTH-1 is sent first.
- data_mod_i  input  MOD_WIDTH  number of bits to send, counted from the MSB; 0 means all DATA_BUS_WIDTH bits.
- data_val_i  input  1  word/mod valid; sampled only when busy_o is 0.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o holds a valid bit this cycle.
- busy_o  output  1  a transfer is in progress; new input is ignored.

Behaviour:
- Reset values, forced while arst_n_i=0:
  - ser_data_o=0, ser_data_val_o=0, busy_o=0.
  - Shift register and bit counter cleared.
  - FSM in IDLE.
- FSM states:
  - IDLE -> SEND on accept of a valid-length word.
  - SEND -> IDLE after the last bit is driven.
- Accept: data_val_i=1 and busy_o=0 at a clk_i edge.
  - data_i is latched into the shift register.
  - Bit count is set to N = (data_mod_i==0) ? DATA_BUS_WIDTH : data_mod_i.
- Short words: data_mod_i=1 or 2 is a short/illegal word and is dropped silently. No bits are sent, busy_o stays 0, FSM stays IDLE.
- Latency: the first bit, data_i[DATA_BUS_WIDTH-1], appears with ser_data_val_o=1 in the cycle after the accept edge.
- Bit sequence: bit k (k=0..N-1) is data_i[DATA_BUS_WIDTH-1-k], driven on consecutive cycles with no gaps.
- busy_o timing:
  - Goes to 1 in the same cycle as the first bit.
  - Stays 1 through the cycle of the last bit, inclusive.
  - busy_o equals ser_data_val_o at all times.
- Back-to-back words: the earliest next accept is the edge at which busy_o is 0. So consecutive words have exactly one idle cycle between them (ser_data_val_o=0 in that cycle).
- While busy_o=1:
  - data_val_i, data_i and data_mod_i are ignored.
  - The latched word is unaffected by input changes.
- Idle output: when ser_data_val_o=0, ser_data_o is 0 (never X, never a stale bit).
- Bit counter: MOD_WIDTH+1 bits wide so that N=DATA_BUS_WIDTH is representable. It decrements by one per sent bit, and the FSM leaves SEND when it reaches 0.
- Reset mid-transfer: all outputs drop to 0 immediately and the transfer is abandoned. The first accept after deassertion starts a fresh word.
- No output flip-flops beyond the shift register, counter and FSM: all three outputs come directly from registered state.

Test Plan:
- Reset then idle, data_val_i=0 for 10 cycles -> ser_data_val_o=0, busy_o=0 and ser_data_o=0 throughout.
- data_i=16'hA5C3, data_mod_i=0, one-cycle data_val_i:
  - ser_data_val_o high for exactly 16 cycles, starting one cycle after the accept.
  - Bit stream is 1010_0101_1100_0011.
  - busy_o mirrors ser_data_val_o.
- data_i=16'hF000, data_mod_i=5 -> exactly 5 valid bits 1,1,1,1,0, then ser_data_val_o=0 and busy_o=0.
- data_mod_i=1, then separately data_mod_i=2, each with data_val_i=1 -> no valid output bits, busy_o stays 0 for 20 cycles.
- data_val_i held at 1 continuously: word0=16'h1234 (mod 0), then data_i changed to 16'hFFFF at the 5th bit -> all 16 bits of 16'h1234 sent unaltered; the next word is accepted only on the idle edge, after a single gap cycle.
- arst_n_i pulsed low mid-transfer, at the 7th bit of 16'hFFFF:
  - Outputs go to 0 immediately, without waiting for a clock.
  - After release, a new 16'h8001 with mod 0 is serialized correctly with no residual bits from the old word.
- Loopback: serializer outputs wired to a DATA_BUS_WIDTH=16 deserializer, 1000 random full-width words -> every received word equals the sent word.
